// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: shared interrupt vector, register index and CTRL bit definitions
package timer_irq_pkg;
   typedef logic [7:0] int_bus_t;
   localparam int_bus_t INT_NONE  = 8'h00;
   localparam int_bus_t INT_TIMER = 8'h01;
   typedef enum logic [2:0] {
      TMR_CTRL   = 3'd0,
      TMR_PRESC  = 3'd1,
      TMR_COUNT  = 3'd2,
      TMR_CMP    = 3'd3,
      TMR_STATUS = 3'd4
   } tmr_reg_e;
   localparam int CTRL_EN = 0;
   localparam int CTRL_IE = 1;
   localparam int CTRL_AR = 2;
   localparam int CTRL_W  = 3;
endpackage

// File: rtl/timer_irq_if.sv
// timer_irq_if: single-cycle register port between software master and timer
interface timer_irq_if #(parameter int DW = 16);
   logic          sel;
   logic          we;
   logic [2:0]    addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   modport master (output sel, we, addr, wdata, input rdata);
   modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_irq_prescaler.sv
// timer_prescaler: divides clk by presc+1, held at zero while disabled or cleared
module timer_prescaler #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic          clear_i,
   input  logic [DW-1:0] presc_i,
   output logic          tick_o
);
   logic [DW-1:0] psc_cnt_q, psc_cnt_d;
   assign tick_o = en_i & (psc_cnt_q == presc_i);
   // next prescaler count: reload on tick, hold at zero when disabled or cleared
   always_comb begin
      psc_cnt_d = (~en_i | clear_i | tick_o) ? '0 : psc_cnt_q + DW'(1);
   end
   // prescaler count register
   always_ff @(posedge clk) begin
      if (rst) psc_cnt_q <= '0;
      else     psc_cnt_q <= psc_cnt_d;
   end
endmodule

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped compare timer driving the timer interrupt line
module timer_irq import timer_irq_pkg::*; #(
   parameter int            DW        = 16,
   parameter logic [DW-1:0] PRESC_RST = '0
) (
   input  logic       clk,
   input  logic       rst,
   timer_irq_if.slave bus,
   output int_bus_t   int_flag,
   output logic       tick_o
);
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DW-1:0]     presc_q, presc_d, count_q, count_d, cmp_q, cmp_d;
   logic [DW-1:0]     rdata_q, rdata_d, rd_mux;
   logic              pend_q, pend_d, tick_q, tick, wr, rd, match;
   logic              wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
   assign wr        = bus.sel & bus.we;
   assign rd        = bus.sel & ~bus.we;
   assign wr_ctrl   = wr & (bus.addr == TMR_CTRL);
   assign wr_presc  = wr & (bus.addr == TMR_PRESC);
   assign wr_count  = wr & (bus.addr == TMR_COUNT);
   assign wr_cmp    = wr & (bus.addr == TMR_CMP);
   assign wr_status = wr & (bus.addr == TMR_STATUS);
   timer_prescaler #(.DW(DW)) u_psc (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ctrl_q[CTRL_EN]),
      .clear_i (wr_ctrl | wr_presc),
      .presc_i (presc_q),
      .tick_o  (tick)
   );
   // a software COUNT write pre-empts the compare; the compare sees the pre-edge CMP
   assign match = tick & ~wr_count & (count_q == cmp_q);
   // register file next state, compare/reload and registered read mux
   always_comb begin
      ctrl_d  = wr_ctrl  ? bus.wdata[CTRL_W-1:0] : ctrl_q;
      presc_d = wr_presc ? bus.wdata : presc_q;
      cmp_d   = wr_cmp   ? bus.wdata : cmp_q;
      count_d = wr_count ? bus.wdata :
                (match & ctrl_q[CTRL_AR]) ? '0 :
                tick ? count_q + DW'(1) : count_q;
      pend_d  = match | (pend_q & ~(wr_status & bus.wdata[0]));
      rd_mux  = (bus.addr == TMR_CTRL)   ? DW'(ctrl_q) :
                (bus.addr == TMR_PRESC)  ? presc_q :
                (bus.addr == TMR_COUNT)  ? count_q :
                (bus.addr == TMR_CMP)    ? cmp_q :
                (bus.addr == TMR_STATUS) ? DW'(pend_q) : '0;
      rdata_d = rd ? rd_mux : rdata_q;
   end
   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q  <= '0;
         presc_q <= PRESC_RST;
         count_q <= '0;
         cmp_q   <= '1;
         pend_q  <= 1'b0;
         rdata_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         pend_q  <= pend_d;
         rdata_q <= rdata_d;
         tick_q  <= tick;
      end
   end
   assign int_flag  = (pend_q & ctrl_q[CTRL_IE]) ? INT_TIMER : INT_NONE;
   assign tick_o    = tick_q;
   assign bus.rdata = rdata_q;
endmodule
